mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage with blocking cache miss handshake
// Optional saturating hit/miss counters are built when MEM_WB_STATS_EN is defined.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_memtoreg,
    input  logic        ex_memwrite,
    input  logic        ex_regwrite,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_write_data,
    input  logic [4:0]  ex_write_reg,
    output logic        memtoreg,
    output logic        memwrite,
    output logic [31:0] INAddress,
    output logic [31:0] INWriteData,
    output logic [4:0]  INWriteReg,
    input  logic        hit,
    input  logic        cache_dataReady,
    input  logic [31:0] read_data_word,
    input  logic [4:0]  OUTWriteReg,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_data
`ifdef MEM_WB_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] req_addr, req_data;
    logic [4:0]  req_reg;
    logic        req_load, req_store, req_regwrite;

    logic        ex_mem, ex_load;
    logic        cap_valid, cap_regwrite;
    logic [31:0] cap_data;
    logic [4:0]  cap_reg;
    logic        hit_evt, miss_evt;

    assign ex_mem  = ex_memtoreg | ex_memwrite;
    assign ex_load = ex_memtoreg;

    always_comb begin
        state_nxt    = state;
        memtoreg     = 1'b0;
        memwrite     = 1'b0;
        INAddress    = 32'd0;
        INWriteData  = 32'd0;
        INWriteReg   = 5'd0;
        stall        = 1'b0;
        cap_valid    = 1'b0;
        cap_regwrite = 1'b0;
        cap_data     = wb_data;
        cap_reg      = wb_write_reg;
        hit_evt      = 1'b0;
        miss_evt     = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        // a load that also claims memwrite is still a load
                        memtoreg    = ex_load;
                        memwrite    = ex_memwrite & ~ex_load;
                        INAddress   = ex_alu_result;
                        INWriteData = ex_write_data;
                        INWriteReg  = ex_write_reg;
                        if (!ex_mem) begin
                            cap_valid    = 1'b1;
                            cap_regwrite = ex_regwrite;
                            cap_data     = ex_alu_result;
                            cap_reg      = ex_write_reg;
                        end else if (hit) begin
                            hit_evt   = 1'b1;
                            cap_valid = 1'b1;
                            if (ex_load) begin
                                cap_regwrite = ex_regwrite;
                                cap_data     = read_data_word;
                                cap_reg      = OUTWriteReg;
                            end
                        end else begin
                            miss_evt  = 1'b1;
                            stall     = 1'b1;
                            state_nxt = WAIT;
                        end
                    end
                end
                WAIT: begin
                    memtoreg    = req_load;
                    memwrite    = req_store;
                    INAddress   = req_addr;
                    INWriteData = req_data;
                    INWriteReg  = req_reg;
                    if (cache_dataReady) begin
                        cap_valid = 1'b1;
                        state_nxt = IDLE;
                        if (req_load) begin
                            cap_regwrite = req_regwrite;
                            cap_data     = read_data_word;
                            cap_reg      = OUTWriteReg;
                        end
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            req_addr     <= 32'd0;
            req_data     <= 32'd0;
            req_reg      <= 5'd0;
            req_load     <= 1'b0;
            req_store    <= 1'b0;
            req_regwrite <= 1'b0;
        end else begin
            state <= state_nxt;
            if (miss_evt) begin
                req_addr     <= ex_alu_result;
                req_data     <= ex_write_data;
                req_reg      <= ex_write_reg;
                req_load     <= ex_load;
                req_store    <= ex_memwrite & ~ex_load;
                req_regwrite <= ex_regwrite;
            end
        end
    end

    // bubbles and stores keep wb_data/wb_write_reg at their previous values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_write_reg <= 5'd0;
            wb_data      <= 32'd0;
        end else begin
            wb_valid     <= cap_valid;
            wb_regwrite  <= cap_regwrite;
            wb_write_reg <= cap_reg;
            wb_data      <= cap_data;
        end
    end

`ifdef MEM_WB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (hit_evt && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (miss_evt && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`else
    logic unused_evt;
    assign unused_evt = hit_evt;
`endif

endmodule
